// File: rtl/token_rx_buffer.sv
// Token receive buffer: accepts forward tokens from an upstream sender into a FIFO,
// answers each with an ack/nack/release backward token, and presents the head downstream.
package token_pkg;
    localparam int DEPTH_FIFO = 16;
    localparam int DATA_W     = 32;

    typedef struct packed {
        logic              v;
        logic              a;
        logic              c;
        logic              r;
        logic [DATA_W-1:0] d;
    } FTk_t;

    typedef struct packed {
        logic n;
        logic t;
        logic v;
        logic c;
    } BTk_t;

    typedef enum logic [1:0] {
        eMPTY  = 2'd0,
        fILL   = 2'd1,
        wAIT   = 2'd2,
        rEVERT = 2'd3
    } fsm_token;
endpackage

module token_rx_buffer
    import token_pkg::*;
#(
    parameter int DEPTH = DEPTH_FIFO
) (
    input  logic                     clock,
    input  logic                     reset,
    input  FTk_t                     I_FTk,
    output BTk_t                     O_BTk,
    output FTk_t                     O_FTk,
    input  BTk_t                     I_BTk,
    output fsm_token                 O_State,
    output logic [$clog2(DEPTH):0]   O_Count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    FTk_t           mem [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic [CW-1:0]  count_next;
    fsm_token       state;
    fsm_token       state_next;
    logic           accept;
    logic           pop;

    // Only the nack bit of the downstream backward token matters.
    logic unused_btk;
    assign unused_btk = ^{I_BTk.t, I_BTk.v, I_BTk.c};

    // Both decisions use pre-edge count/state, so a full buffer refuses even while popping.
    assign accept = I_FTk.v && (count < CW'(DEPTH)) && (state != rEVERT);
    assign pop    = (count != '0) && !I_BTk.n;

    always_comb begin
        count_next = count;
        if (accept && !pop) begin
            count_next = count + 1'b1;
        end else if (!accept && pop) begin
            count_next = count - 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        if (accept && I_FTk.r) begin
            state_next = rEVERT;
        end else if (state == rEVERT) begin
            if (count_next == '0) begin
                state_next = eMPTY;
            end
        end else if (count_next == '0) begin
            state_next = eMPTY;
        end else if (count_next == CW'(DEPTH)) begin
            state_next = wAIT;
        end else begin
            state_next = fILL;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            state  <= eMPTY;
            O_BTk  <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count   <= count_next;
            state   <= state_next;
            O_BTk.v <= accept;
            O_BTk.c <= accept && I_FTk.c;
            O_BTk.t <= accept && I_FTk.r;
            O_BTk.n <= I_FTk.v && !accept;
        end
    end

    // Storage needs no reset: entries are only visible while count is non-zero.
    always_ff @(posedge clock) begin
        if (accept) begin
            mem[wr_ptr] <= I_FTk;
        end
    end

    always_comb begin
        O_FTk = '0;
        if (count != '0) begin
            O_FTk   = mem[rd_ptr];
            O_FTk.v = 1'b1;
        end
    end

    assign O_State = state;
    assign O_Count = count;

endmodule
